// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the chunked adder/subtractor.
//   - mode_t and the MODE_* operation selects
//   - state_e, the controller state encoding
//   - is_sub / is_sat helpers that decode the mode bits
package addsub_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD  = 2'b00;
  localparam mode_t MODE_SUB  = 2'b01;
  localparam mode_t MODE_SADD = 2'b10;
  localparam mode_t MODE_SSUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit 0 of the mode selects subtraction: B is inverted and carry-in is 1.
  function automatic logic is_sub(input mode_t m);
    return m[0];
  endfunction

  // Bit 1 of the mode selects saturation on signed overflow.
  function automatic logic is_sat(input mode_t m);
    return m[1];
  endfunction

endpackage

// File: rtl/addsub_chunked_if.sv
// addsub_chunked_if: request/result bundle for addsub_chunked.
//   master (sequencer): drives start, mode, a, b; observes busy, done, s, cout, ovf
//   slave  (datapath) : the reverse direction
interface addsub_chunked_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             start;
  mode_t            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple-carry adder slice.
//   x, y  : CHUNK-bit addends
//   cin   : carry in
//   sum   : CHUNK-bit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow detection)
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    logic [CHUNK:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout  = c[CHUNK];
    c_msb = c[CHUNK-1];
  end

endmodule

// File: rtl/addsub_chunked.sv
// addsub_chunked: sequential two's-complement add/sub, CHUNK bits per clock,
// least significant chunk first, with a start/done handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of addsub_chunked_if
//           start/mode/a/b are sampled only when not busy (IDLE or DONE);
//           busy is high for the N = WIDTH/CHUNK run cycles, done pulses for
//           one cycle afterwards; s/cout/ovf change only on the final run cycle.
module addsub_chunked
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_chunked_if.slave     bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Operands and partial result viewed as an array of chunks so idx can
  // select a slice directly.
  typedef logic [N-1:0][CHUNK-1:0] chunks_t;

  state_e           state_q, state_d;
  chunks_t          a_q, a_d;
  chunks_t          b_q, b_d;
  chunks_t          res_q, res_d;
  logic             sat_q, sat_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] ch_sum_s;
  logic             ch_cout_s;
  logic             ch_cmsb_s;
  logic             last_s;
  logic             ovf_s;

  // Clamp value on overflow: the result takes the sign of operand A.
  function automatic logic [WIDTH-1:0] sat_value(input logic a_neg);
    logic [WIDTH-1:0] v;
    if (a_neg) begin
      v = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v;
  endfunction

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x     (a_q[idx_q]),
    .y     (b_q[idx_q]),
    .cin   (carry_q),
    .sum   (ch_sum_s),
    .cout  (ch_cout_s),
    .c_msb (ch_cmsb_s)
  );

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    last_s  = (idx_q == IDX_W'(N - 1));
    // Signed overflow: carry into the MSB differs from carry out of it.
    ovf_s   = ch_cmsb_s ^ ch_cout_s;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
          b_d     = is_sub(bus.mode) ? ~bus.b : bus.b;
          sat_d   = is_sat(bus.mode);
          carry_d = is_sub(bus.mode);
          idx_d   = {IDX_W{1'b0}};
          res_d   = {WIDTH{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d[idx_q] = ch_sum_s;
        carry_d      = ch_cout_s;
        idx_d        = idx_q + IDX_W'(1);
        if (last_s) begin
          // res_d already holds the final chunk here, so s never shows a
          // partial result.
          s_d     = (sat_q && ovf_s) ? sat_value(a_q[N-1][CHUNK-1]) : WIDTH'(res_d);
          cout_d  = ch_cout_s;
          ovf_d   = ovf_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: self-checking bench for addsub_chunked.
// A 16/4 instance takes directed, protocol and random operations; a 4/1
// instance takes an exhaustive sweep. Expected values come from an
// integer-arithmetic reference model.
module tb_addsub_chunked;
  import addsub_pkg::*;

  localparam int BOUND = 40;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  addsub_chunked_if #(.WIDTH(16)) if16 ();
  addsub_chunked_if #(.WIDTH(4))  if4 ();

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  addsub_chunked #(.WIDTH(4), .CHUNK(1)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_op(input int w, input logic [1:0] m,
                                 input longint av, input longint bv,
                                 output longint so, output logic co, output logic oo);
    longint mask, half, full, sa, sb, sr;
    mask = (64'sd1 <<< w) - 64'sd1;
    half = 64'sd1 <<< (w - 1);
    if (m[0]) full = av + ((~bv) & mask) + 64'sd1;
    else      full = av + bv;
    co = ((full >>> w) & 64'sd1) != 64'sd0;
    sa = (av >= half) ? av - 2 * half : av;
    sb = (bv >= half) ? bv - 2 * half : bv;
    sr = m[0] ? sa - sb : sa + sb;
    oo = (sr >= half) || (sr < -half);
    so = full & mask;
    if (m[1] && oo) so = (sr > 64'sd0) ? half - 64'sd1 : half;
  endfunction

  // From a negedge, wait for done (bounded); returns negedges waited and busy count.
  task automatic wait16(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (if16.done !== 1'b1 && lat < BOUND) begin
      if (if16.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("done16_seen", {31'd0, if16.done}, 32'd1);
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (if4.done !== 1'b1 && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    chk("done4_seen", {31'd0, if4.done}, 32'd1);
  endtask

  // Issue from a negedge; returns at the negedge in the done cycle.
  task automatic op16(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                      output logic [15:0] so, output logic co, output logic oo,
                      output int lat, output int bcnt);
    if16.start = 1'b1; if16.mode = m; if16.a = av; if16.b = bv;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom); if16.mode = 2'($urandom);
    wait16(lat, bcnt);
    so = if16.s; co = if16.cout; oo = if16.ovf;
  endtask

  task automatic op4(input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv,
                     output logic [3:0] so, output logic co, output logic oo, output int lat);
    if4.start = 1'b1; if4.mode = m; if4.a = av; if4.b = bv;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    if4.a = 4'($urandom); if4.b = 4'($urandom); if4.mode = 2'($urandom);
    wait4(lat);
    so = if4.s; co = if4.cout; oo = if4.ovf;
  endtask

  task automatic dir16(input string tag, input logic [1:0] m, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] es, input logic ec,
                       input logic eo);
    logic [15:0] so; logic co, oo; int lat, bcnt;
    op16(m, av, bv, so, co, oo, lat, bcnt);
    chk({tag, "_s"},    32'(so), 32'(es));
    chk({tag, "_cout"}, 32'(co), 32'(ec));
    chk({tag, "_ovf"},  32'(oo), 32'(eo));
    chk({tag, "_lat"},  32'(lat), 32'd4);
    chk({tag, "_busy"}, 32'(bcnt), 32'd4);
  endtask

  initial begin
    logic [15:0] so, av, bv;
    logic [3:0]  so4;
    logic        co, oo;
    logic [1:0]  m;
    longint      es;
    logic        ec, eo;
    int          lat, bcnt, dcnt;
    time         t1;

    rst_n = 1'b0;
    if16.start = 1'b0; if16.mode = MODE_ADD; if16.a = 16'd0; if16.b = 16'd0;
    if4.start  = 1'b0; if4.mode  = MODE_ADD; if4.a  = 4'd0;  if4.b  = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if16.busy), 32'd0);
    chk("rst_done", 32'(if16.done), 32'd0);
    chk("rst_s",    32'(if16.s),    32'd0);
    chk("rst_cout", 32'(if16.cout), 32'd0);
    chk("rst_ovf",  32'(if16.ovf),  32'd0);
    chk("rst_s4",   32'(if4.s),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the plan.
    dir16("add1",  MODE_ADD,  16'h1234, 16'h0FF0, 16'h2224, 1'b0, 1'b0);
    dir16("sub1",  MODE_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    dir16("sub2",  MODE_SUB,  16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    dir16("addov", MODE_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    dir16("sadd",  MODE_SADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    dir16("ssub",  MODE_SSUB, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1);
    dir16("saddn", MODE_SADD, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

    // Output hold after DONE, then idle.
    @(negedge clk);
    chk("hold_s",    32'(if16.s),    32'h8000);
    chk("hold_done", 32'(if16.done), 32'd0);
    chk("hold_busy", 32'(if16.busy), 32'd0);

    // Back-to-back: start in the DONE cycle.
    op16(MODE_ADD, 16'h0100, 16'h0023, so, co, oo, lat, bcnt);
    t1 = $time;
    op16(MODE_SUB, 16'h0100, 16'h0023, so, co, oo, lat, bcnt);
    chk("b2b_gap", 32'(($time - t1) / 10), 32'd5);
    chk("b2b_s",   32'(so), 32'h00DD);
    chk("b2b_cout", 32'(co), 32'd1);

    // Start pulsed mid-RUN with different operands is ignored.
    @(negedge clk);
    if16.start = 1'b1; if16.mode = MODE_ADD; if16.a = 16'h1111; if16.b = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    @(negedge clk);
    if16.start = 1'b1; if16.mode = MODE_SUB; if16.a = 16'hFFFF; if16.b = 16'h0F0F;
    @(negedge clk);
    if16.start = 1'b0;
    wait16(lat, bcnt);
    chk("midrun_s",    32'(if16.s),    32'h3333);
    chk("midrun_cout", 32'(if16.cout), 32'd0);
    @(negedge clk);
    chk("midrun_idle", 32'(if16.busy), 32'd0);

    // Reset in RUN cycle 2 aborts the operation.
    if16.start = 1'b1; if16.mode = MODE_ADD; if16.a = 16'hF000; if16.b = 16'h1001;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(if16.busy), 32'd0);
    chk("abort_s",    32'(if16.s),    32'd0);
    chk("abort_done", 32'(if16.done), 32'd0);
    chk("abort_cout", 32'(if16.cout), 32'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if16.done === 1'b1) dcnt++;
    end
    chk("abort_nodone", 32'(dcnt), 32'd0);

    // Random operations with edge-value bias.
    for (int i = 0; i < 200; i++) begin
      m  = 2'($urandom);
      av = ($urandom_range(0, 3) == 0) ? ((i & 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? ((i & 2) ? 16'hFFFF : 16'h0001) : 16'($urandom);
      op16(m, av, bv, so, co, oo, lat, bcnt);
      ref_op(16, m, longint'(av), longint'(bv), es, ec, eo);
      chk("rnd_s",    32'(so), 32'(es));
      chk("rnd_cout", 32'(co), 32'(ec));
      chk("rnd_ovf",  32'(oo), 32'(eo));
    end

    // Exhaustive sweep at WIDTH=4, CHUNK=1, all modes.
    for (int mi = 0; mi < 4; mi++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          op4(2'(mi), 4'(ai), 4'(bi), so4, co, oo, lat);
          ref_op(4, 2'(mi), longint'(ai), longint'(bi), es, ec, eo);
          chk("sw_s",    32'(so4), 32'(es));
          chk("sw_cout", 32'(co),  32'(ec));
          chk("sw_ovf",  32'(oo),  32'(eo));
          chk("sw_lat",  32'(lat), 32'd4);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_chunked.md
# addsub_chunked

Parametrised, sequential two's-complement adder/subtractor that resolves a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, with a start/done handshake. It is the successor to our 4-bit combinational add/sub block: it generalises width, splits the carry chain over cycles, and adds signed-overflow detection and optional saturation. It sits behind any sequencer that issues one operation at a time and waits for `done`.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of `CHUNK`, and at least 2.
- `CHUNK`, default 4: bits resolved per cycle. Define `N = WIDTH/CHUNK`.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: request a new operation. Sampled only when `busy` is 0.
- `mode`, input, 2: operation select.
  - 00 = add.
  - 01 = sub.
  - 10 = saturating add.
  - 11 = saturating sub.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; result outputs are valid from this cycle.
- `s`, output, WIDTH: result.
- `cout`, output, 1: raw carry out of the MSB. For sub, 1 means no borrow.
- `ovf`, output, 1: signed overflow of the unsaturated result.

## Operation
- **States:** IDLE, RUN, DONE. Encoding lives in the package.
- **IDLE, `start`=1:**
  - Latch `a` and `mode`.
  - Latch `b` as-is for add and `~b` for sub.
  - Preload the carry register with `mode[0]`.
  - Clear chunk index `idx`.
  - Go to RUN.
- **RUN, each cycle:**
  - Add chunk `idx` of A, chunk `idx` of B' and the carry register.
  - Write the sum into bits `[idx*CHUNK +: CHUNK]` of the working result register.
  - Update the carry register; increment `idx`.
- **RUN, cycle with `idx == N-1`:**
  - Also capture the carry into the MSB, `c_msb`.
  - Compute `ovf = c_msb ^ carry_out`.
  - Load the output registers: `s`, `cout` = carry out, `ovf`.
  - Go to DONE.
- **Saturation:**
  - Applies only when `mode[1]`=1 and `ovf`=1.
  - `s` = `{1'b0,{WIDTH-1{1'b1}}}` if the latched `a` MSB is 0, otherwise `{1'b1,{WIDTH-1{1'b0}}}`.
  - `cout` and `ovf` still report raw values.
- **DONE:**
  - `done`=1 and `busy`=0 for exactly one cycle.
  - `start`=1 here is accepted exactly as in IDLE (go to RUN); otherwise go to IDLE.
- **Output hold:** `s`, `cout` and `ovf` hold their values from DONE until the next operation's final RUN cycle. They never show partial results.
- **Start while busy:** `start` during RUN is ignored; the operands are not re-latched.
- **Input stability:** `a`, `b` and `mode` may change freely after the start cycle.

## Timing
- **Latency:** `start` sampled at edge E0. RUN occupies the cycles after E0 through E(N). `done`=1 in the cycle after edge E(N). This gives N cycles from accept to `done`.
- **Throughput:** one operation per N+1 cycles in the back-to-back case. A start issued in the DONE cycle is accepted.
- **`busy`:** 1 exactly during the N RUN cycles.
- **Reset values:** state IDLE; `busy`=0, `done`=0, `s`=0, `cout`=0, `ovf`=0; `idx`=0; working registers 0.
- **Reset mid-RUN:** the operation is aborted. The next cycle shows all outputs at their reset values and no `done` pulse is produced.
- **Degenerate split:** `CHUNK == WIDTH` gives N=1, so `done` appears 1 cycle after the start edge.

## Structure
- **Package `addsub_pkg`:**
  - Mode localparams `MODE_ADD`, `MODE_SUB`, `MODE_SADD`, `MODE_SSUB`.
  - State encodings `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- **Sub-module `addsub_chunk`:**
  - Combinational CHUNK-bit ripple adder.
  - Inputs: `x`, `y`, `cin`. Outputs: `sum`, `cout`, `c_msb` (carry into its top bit).
  - Instantiated once and time-multiplexed via `idx`.
- **Top level:** contains the FSM, operand and working registers, the saturation mux and the output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
1. Add `0x1234 + 0x0FF0` → `s=0x2224`, `cout=0`, `ovf=0`. `done` 4 cycles after the start edge; `busy` high for 4 cycles.
2. Sub `0x0005 - 0x0007` → `s=0xFFFE`, `cout=0`, `ovf=0`. Sub `0x0007 - 0x0005` → `s=0x0002`, `cout=1`.
3. Add `0x7FFF + 0x0001` → `s=0x8000`, `ovf=1`. The same operands in saturating-add mode → `s=0x7FFF`, `ovf=1`, `cout=0`.
4. Saturating sub `0x8000 - 0x0001` → `s=0x8000`, `ovf=1`, `cout=1`.
5. Protocol checks:
   - `start` pulsed mid-RUN with new operands → ignored; the result matches the original operands.
   - `start` in the DONE cycle → accepted; second `done` exactly 5 cycles after the first.
   - `rst_n`=0 in RUN cycle 2 → `busy=0`, `s=0`, and no `done` pulse.
6. WIDTH=4, CHUNK=1: exhaustive sweep over all `a`, `b` and both add/sub modes (512 operations). Compare `s` and `cout` against `a+b` and `a+~b+1`, and `ovf` against a signed reference model.
